// File: rtl/uart_rx_ctrl_if.sv
// Host/receiver-facing signal bundle of the UART receive controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enable;
    logic          rx_busy;
    logic [7:0]    rx_dout;
    logic          rxclken;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_en;
    logic [CW-1:0] fifo_count;
    logic          overrun;
    logic          timeout;
    logic          err_clr;

    modport slave (
        input  enable, rx_busy, rx_dout, rd_en, err_clr,
        output rxclken, rd_data, rd_valid, fifo_count, overrun, timeout
    );

    modport master (
        output enable, rx_busy, rx_dout, rd_en, err_clr,
        input  rxclken, rd_data, rd_valid, fifo_count, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: gates the receiver, detects finished frames,
// buffers bytes in a first-word-fall-through FIFO and flags overrun/watchdog timeout.
module uart_rx_ctrl #(
    parameter int DEPTH          = 4,
    parameter int MAX_FRAME_CLKS = 11935
) (
    input  logic           rxclk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [15:0] WD_LAST = 16'(MAX_FRAME_CLKS - 1);
    localparam logic [15:0] WD_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_IDLE     = 2'd1,
        S_RECV     = 2'd2,
        S_ABORT    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rxclken_q, rxclken_d;
    logic [15:0]   watchdog_q, watchdog_d;
    logic          busy_q, en_q;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic frame_done_s;
    logic timeout_set_s;
    logic overrun_set_s;
    logic full_s;
    logic do_pop_s;
    logic do_push_s;

    // Frame boundary and FIFO push/pop decisions.
    always_comb begin
        frame_done_s  = busy_q & ~bus.rx_busy & en_q & (state_q == S_RECV);
        full_s        = (count_q == CW'(DEPTH));
        do_pop_s      = bus.rd_en & (count_q != CW'(0));
        do_push_s     = frame_done_s & (~full_s | do_pop_s);
        overrun_set_s = frame_done_s & full_s & ~do_pop_s;
    end

    // Sequencing FSM with watchdog; rxclken decoded from the next state.
    always_comb begin
        state_d       = state_q;
        watchdog_d    = watchdog_q;
        timeout_set_s = 1'b0;
        case (state_q)
            S_DISABLED: begin
                if (bus.enable) state_d = S_IDLE;
                else            state_d = S_DISABLED;
            end
            S_IDLE: begin
                if (!bus.enable) begin
                    state_d = S_DISABLED;
                end else if (bus.rx_busy) begin
                    state_d    = S_RECV;
                    watchdog_d = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (!bus.enable) begin
                    state_d = S_ABORT;
                end else if (frame_done_s) begin
                    state_d = S_IDLE;
                end else if (watchdog_q == WD_LAST) begin
                    state_d       = S_ABORT;
                    timeout_set_s = 1'b1;
                end else if (watchdog_q != WD_MAX) begin
                    watchdog_d = watchdog_q + 16'd1;
                end else begin
                    watchdog_d = watchdog_q;
                end
            end
            S_ABORT: begin
                if (bus.enable) state_d = S_IDLE;
                else            state_d = S_DISABLED;
            end
            default: state_d = S_DISABLED;
        endcase
        rxclken_d = (state_d == S_IDLE) || (state_d == S_RECV);
    end

    // Pointer/count update and next head byte; a byte written this cycle can be the new head.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        if (do_push_s) wr_ptr_d = wr_ptr_q + PW'(1);
        else           wr_ptr_d = wr_ptr_q;
        if (do_pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
        else           rd_ptr_d = rd_ptr_q;
        if (do_push_s && !do_pop_s)      count_d = count_q + CW'(1);
        else if (!do_push_s && do_pop_s) count_d = count_q - CW'(1);
        else                             count_d = count_q;
        if (count_d != CW'(0)) begin
            if (do_push_s && (wr_ptr_q == rd_ptr_d)) rd_data_d = bus.rx_dout;
            else                                     rd_data_d = mem_q[rd_ptr_d];
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = (count_d != CW'(0));
    end

    // Sticky error flags; a same-cycle set overrides the clear.
    always_comb begin
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (bus.err_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
            timeout_d = timeout_q;
        end
        if (overrun_set_s) overrun_d = 1'b1;
        else               overrun_d = overrun_d;
        if (timeout_set_s) timeout_d = 1'b1;
        else               timeout_d = timeout_d;
    end

    // All state registers with synchronous reset.
    always_ff @(posedge rxclk) begin
        if (rst) begin
            state_q    <= S_DISABLED;
            rxclken_q  <= 1'b0;
            watchdog_q <= 16'd0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            rxclken_q  <= rxclken_d;
            watchdog_q <= watchdog_d;
            busy_q     <= bus.rx_busy;
            en_q       <= rxclken_q;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            if (do_push_s) mem_q[wr_ptr_q] <= bus.rx_dout;
        end
    end

    assign bus.rxclken    = rxclken_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;
endmodule
